// File: rtl/color_scan_sequencer_if.sv
// Sensor-pin and host handshake bundle for the colour scan sequencer.
// master = host/sensor side, slave = sequencer side.
interface color_scan_sequencer_if #(
  parameter int CNT_W = 20
);
  logic             start;
  logic             continuous;
  logic [1:0]       scale_cfg;
  logic             sensor_freq;
  logic [1:0]       scale;
  logic [1:0]       filter;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] red_cnt;
  logic [CNT_W-1:0] blue_cnt;
  logic [CNT_W-1:0] green_cnt;
  logic [CNT_W-1:0] clear_cnt;
  logic             sat;

  modport master (
    output start, continuous, scale_cfg, sensor_freq,
    input  scale, filter, busy, done,
    input  red_cnt, blue_cnt, green_cnt, clear_cnt, sat
  );

  modport slave (
    input  start, continuous, scale_cfg, sensor_freq,
    output scale, filter, busy, done,
    output red_cnt, blue_cnt, green_cnt, clear_cnt, sat
  );
endinterface

// File: rtl/color_scan_sequencer.sv
// Steps a TCS3200-style sensor through red, blue, green, clear; settles, then
// counts synchronized rising edges over a fixed gate per filter.
module color_scan_sequencer #(
  parameter int WINDOW_CYCLES = 100000,
  parameter int SETTLE_CYCLES = 1000,
  parameter int CNT_W         = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  color_scan_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_COUNT  = 2'd2
  } state_t;

  localparam logic [1:0] F_RED   = 2'b00;
  localparam logic [1:0] F_BLUE  = 2'b01;
  localparam logic [1:0] F_GREEN = 2'b11;
  localparam logic [1:0] F_CLEAR = 2'b10;

  localparam int TMAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0]    SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]    WINDOW_LAST = TW'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TW-1:0]    r_timer;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic [CNT_W-1:0] r_acc;
  logic             r_sticky;
  logic [1:0]       r_filter;
  logic [1:0]       r_scale_lat;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_sh_red;
  logic [CNT_W-1:0] r_sh_blue;
  logic [CNT_W-1:0] r_sh_green;
  logic [CNT_W-1:0] r_red;
  logic [CNT_W-1:0] r_blue;
  logic [CNT_W-1:0] r_green;
  logic [CNT_W-1:0] r_clear;
  logic             r_sat;

  logic             w_edge;
  logic [CNT_W-1:0] w_acc_nxt;
  logic             w_sat_now;
  logic             w_start_scan;
  logic             w_chan_end;
  logic             w_scan_end;
  logic             w_restart;

  assign w_edge    = r_sync2 & ~r_prev;
  assign w_acc_nxt = (r_acc == CNT_MAX) ? r_acc : r_acc + CNT_W'(w_edge);
  // Includes a saturation that happens on the final window cycle itself.
  assign w_sat_now = r_sticky | ((r_state == S_COUNT) && (w_acc_nxt == CNT_MAX));

  always_comb begin
    w_state_nxt  = r_state;
    w_start_scan = 1'b0;
    w_chan_end   = 1'b0;
    w_scan_end   = 1'b0;
    w_restart    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_start_scan = 1'b1;
          w_state_nxt  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_timer == SETTLE_LAST) begin
          w_state_nxt = S_COUNT;
        end
      end
      S_COUNT: begin
        if (r_timer == WINDOW_LAST) begin
          w_chan_end = 1'b1;
          if (r_filter == F_CLEAR) begin
            w_scan_end = 1'b1;
            if (bus.continuous) begin
              w_restart   = 1'b1;
              w_state_nxt = S_SETTLE;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_state_nxt = S_SETTLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // One timer serves both phases; it restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if ((w_state_nxt != r_state) || (r_state == S_IDLE)) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= bus.sensor_freq;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_sticky <= 1'b0;
    end else if (w_start_scan || w_restart) begin
      r_acc    <= '0;
      r_sticky <= 1'b0;
    end else if (r_state == S_COUNT) begin
      r_acc <= w_chan_end ? '0 : w_acc_nxt;
      if (w_acc_nxt == CNT_MAX) begin
        r_sticky <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filter    <= F_RED;
      r_scale_lat <= 2'b00;
      r_busy      <= 1'b0;
    end else if (w_start_scan) begin
      r_filter    <= F_RED;
      r_scale_lat <= bus.scale_cfg;
      r_busy      <= 1'b1;
    end else if (w_chan_end) begin
      case (r_filter)
        F_RED:   r_filter <= F_BLUE;
        F_BLUE:  r_filter <= F_GREEN;
        F_GREEN: r_filter <= F_CLEAR;
        default: r_filter <= F_RED;
      endcase
      if (w_restart) begin
        r_scale_lat <= bus.scale_cfg;
      end else if (w_scan_end) begin
        r_busy <= 1'b0;
      end
    end
  end

  // Per-channel results park in shadows so the visible counts move together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_red   <= '0;
      r_sh_blue  <= '0;
      r_sh_green <= '0;
    end else if (w_chan_end) begin
      case (r_filter)
        F_RED:   r_sh_red   <= w_acc_nxt;
        F_BLUE:  r_sh_blue  <= w_acc_nxt;
        F_GREEN: r_sh_green <= w_acc_nxt;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_red   <= '0;
      r_blue  <= '0;
      r_green <= '0;
      r_clear <= '0;
      r_sat   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_scan_end;
      if (w_scan_end) begin
        r_red   <= r_sh_red;
        r_blue  <= r_sh_blue;
        r_green <= r_sh_green;
        r_clear <= w_acc_nxt;
        r_sat   <= w_sat_now;
      end
    end
  end

  // Sensor is held in power-down whenever no scan is running.
  assign bus.scale     = (r_state == S_IDLE) ? 2'b00 : r_scale_lat;
  assign bus.filter    = r_filter;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.red_cnt   = r_red;
  assign bus.blue_cnt  = r_blue;
  assign bus.green_cnt = r_green;
  assign bus.clear_cnt = r_clear;
  assign bus.sat       = r_sat;

endmodule

// File: tb/tb_color_scan_sequencer.sv
// Runs two sequencers (8-bit and 5-bit counts) in lockstep from one sensor
// model; expected results are queued at start and checked at each done.
module tb_color_scan_sequencer;

  localparam int W = 100;
  localparam int S = 10;
  localparam int SCAN = 4 * (S + W);

  typedef struct packed {
    logic [7:0]  ra, ba, ga, ca;
    logic        sa;
    logic [4:0]  rb, bb, gb, cb;
    logic        sb;
    logic        done_b;
    int unsigned at;
  } res_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       continuous;
  logic [1:0] scale_cfg;
  logic       sensor;
  int         cyc;
  int         tick;
  int         p_red, p_blue, p_green, p_clear;
  int         n_cmp;
  int         n_bad;
  res_t       sb[$];

  color_scan_sequencer_if #(.CNT_W(8)) if_a ();
  color_scan_sequencer_if #(.CNT_W(5)) if_b ();

  assign if_a.start       = start;
  assign if_a.continuous  = continuous;
  assign if_a.scale_cfg   = scale_cfg;
  assign if_a.sensor_freq = sensor;
  assign if_b.start       = start;
  assign if_b.continuous  = continuous;
  assign if_b.scale_cfg   = scale_cfg;
  assign if_b.sensor_freq = sensor;

  color_scan_sequencer #(.WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .CNT_W(8)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a)
  );

  color_scan_sequencer #(.WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .CNT_W(5)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Free-running square wave; period follows the filter currently selected.
  initial begin
    int p;
    tick   = 0;
    sensor = 1'b0;
    forever begin
      @(negedge clk);
      tick++;
      case (if_a.filter)
        2'b00:   p = p_red;
        2'b01:   p = p_blue;
        2'b11:   p = p_green;
        default: p = p_clear;
      endcase
      sensor = ((tick % p) < (p / 2));
    end
  end

  function automatic res_t model(input int pr, input int pb, input int pg, input int pc, input int at);
    int n[4];
    res_t r;
    n[0] = W / pr; n[1] = W / pb; n[2] = W / pg; n[3] = W / pc;
    r.ra = 8'((n[0] > 255) ? 255 : n[0]);
    r.ba = 8'((n[1] > 255) ? 255 : n[1]);
    r.ga = 8'((n[2] > 255) ? 255 : n[2]);
    r.ca = 8'((n[3] > 255) ? 255 : n[3]);
    r.sa = (n[0] >= 255) || (n[1] >= 255) || (n[2] >= 255) || (n[3] >= 255);
    r.rb = 5'((n[0] > 31) ? 31 : n[0]);
    r.bb = 5'((n[1] > 31) ? 31 : n[1]);
    r.gb = 5'((n[2] > 31) ? 31 : n[2]);
    r.cb = 5'((n[3] > 31) ? 31 : n[3]);
    r.sb = (n[0] >= 31) || (n[1] >= 31) || (n[2] >= 31) || (n[3] >= 31);
    r.done_b = 1'b1;
    r.at = at;
    return r;
  endfunction

  function automatic logic [1:0] exp_filter(input int k);
    case ((k % SCAN) / (S + W))
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic set_periods(input int pr, input int pb, input int pg, input int pc);
    p_red = pr; p_blue = pb; p_green = pg; p_clear = pc;
  endtask

  task automatic pulse_start(input logic [1:0] cfg, output int t0);
    @(negedge clk);
    scale_cfg = cfg;
    start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done on DUT A, tracking busy/scale/filter on the way.
  task automatic wait_done(input int t0, input int limit, input logic [1:0] exp_scale,
                           output res_t obs, output bit timeout, output bit path_bad);
    timeout  = 1'b1;
    path_bad = 1'b0;
    obs      = '0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (if_a.done) begin
        obs.ra = if_a.red_cnt;  obs.ba = if_a.blue_cnt;
        obs.ga = if_a.green_cnt; obs.ca = if_a.clear_cnt; obs.sa = if_a.sat;
        obs.rb = if_b.red_cnt;  obs.bb = if_b.blue_cnt;
        obs.gb = if_b.green_cnt; obs.cb = if_b.clear_cnt; obs.sb = if_b.sat;
        obs.done_b = if_b.done;
        obs.at = cyc;
        timeout = 1'b0;
        break;
      end
      if (if_a.busy !== 1'b1 || if_a.scale !== exp_scale || if_a.filter !== exp_filter(cyc - t0))
        path_bad = 1'b1;
    end
  endtask

  task automatic test_reset_initial;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({if_a.scale, if_a.filter, if_a.busy, if_a.done, if_a.red_cnt, if_a.blue_cnt,
         if_a.green_cnt, if_a.clear_cnt, if_a.sat} !== '0) begin
      n_bad++;
      $display("FAIL reset_init_a: got %h want 0", {if_a.scale, if_a.filter, if_a.busy, if_a.done,
               if_a.red_cnt, if_a.blue_cnt, if_a.green_cnt, if_a.clear_cnt, if_a.sat});
    end
    n_cmp++;
    if ({if_b.busy, if_b.done, if_b.red_cnt, if_b.clear_cnt, if_b.sat} !== '0) begin
      n_bad++;
      $display("FAIL reset_init_b: got %h want 0", {if_b.busy, if_b.done, if_b.red_cnt, if_b.clear_cnt, if_b.sat});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int t0; res_t obs, ex; bit to, pb;
    set_periods(10, 10, 10, 10);
    pulse_start(2'b10, t0);
    sb.push_back(model(10, 10, 10, 10, t0 + SCAN));
    wait_done(t0, SCAN + 50, 2'b10, obs, to, pb);
    ex = sb.pop_front();
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL basic_timeout: got %0b want 0", to); end
    n_cmp++; if (pb !== 1'b0) begin n_bad++; $display("FAIL basic_path: busy/scale/filter wrong flag %0b want 0", pb); end
    n_cmp++; if (obs !== ex) begin n_bad++; $display("FAIL basic_result: got %h want %h", obs, ex); end
    n_cmp++; if ({if_a.busy, if_a.scale} !== 3'b000) begin n_bad++; $display("FAIL basic_idle_at_done: busy,scale got %b want 000", {if_a.busy, if_a.scale}); end
    @(posedge clk); #1;
    n_cmp++; if (if_a.done !== 1'b0) begin n_bad++; $display("FAIL basic_done_width: got %b want 0", if_a.done); end
  endtask

  task automatic test_per_filter;
    int t0; res_t obs, ex; bit to, pb;
    set_periods(4, 5, 10, 2);
    pulse_start(2'b01, t0);
    sb.push_back(model(4, 5, 10, 2, t0 + SCAN));
    wait_done(t0, SCAN + 50, 2'b01, obs, to, pb);
    ex = sb.pop_front();
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL perfilter_timeout: got %0b want 0", to); end
    n_cmp++; if (pb !== 1'b0) begin n_bad++; $display("FAIL perfilter_path: flag %0b want 0", pb); end
    n_cmp++; if (obs !== ex) begin n_bad++; $display("FAIL perfilter_result: got %h want %h", obs, ex); end
  endtask

  task automatic test_saturation;
    int t0; res_t obs, ex; bit to, pb;
    set_periods(2, 2, 2, 2);
    pulse_start(2'b11, t0);
    sb.push_back(model(2, 2, 2, 2, t0 + SCAN));
    wait_done(t0, SCAN + 50, 2'b11, obs, to, pb);
    ex = sb.pop_front();
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL sat_timeout: got %0b want 0", to); end
    n_cmp++; if (obs !== ex) begin n_bad++; $display("FAIL sat_result: got %h want %h", obs, ex); end
    set_periods(10, 10, 10, 10);
    repeat (5) @(negedge clk);
    pulse_start(2'b11, t0);
    sb.push_back(model(10, 10, 10, 10, t0 + SCAN));
    wait_done(t0, SCAN + 50, 2'b11, obs, to, pb);
    ex = sb.pop_front();
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL unsat_timeout: got %0b want 0", to); end
    n_cmp++; if (obs !== ex) begin n_bad++; $display("FAIL unsat_result: got %h want %h", obs, ex); end
  endtask

  task automatic test_start_ignored;
    int t0; res_t obs, ex; bit to, pb, extra;
    set_periods(5, 5, 5, 5);
    pulse_start(2'b10, t0);
    sb.push_back(model(5, 5, 5, 5, t0 + SCAN));
    fork
      wait_done(t0, SCAN + 50, 2'b10, obs, to, pb);
      begin
        while (cyc < t0 + 50) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        while (cyc < t0 + 300) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
      end
    join
    ex = sb.pop_front();
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL ignored_timeout: got %0b want 0", to); end
    n_cmp++; if (pb !== 1'b0) begin n_bad++; $display("FAIL ignored_path: flag %0b want 0", pb); end
    n_cmp++; if (obs !== ex) begin n_bad++; $display("FAIL ignored_result: got %h want %h", obs, ex); end
    extra = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if (if_a.done || if_a.busy) extra = 1'b1;
    end
    n_cmp++; if (extra !== 1'b0) begin n_bad++; $display("FAIL ignored_queued: extra activity %0b want 0", extra); end
  endtask

  task automatic test_start_held;
    int t0, t1; res_t obs, ex; bit to, pb;
    set_periods(10, 10, 10, 10);
    @(negedge clk);
    scale_cfg = 2'b01;
    start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    sb.push_back(model(10, 10, 10, 10, t0 + SCAN));
    wait_done(t0, SCAN + 50, 2'b01, obs, to, pb);
    ex = sb.pop_front();
    n_cmp++; if (obs !== ex) begin n_bad++; $display("FAIL held_first: got %h want %h", obs, ex); end
    n_cmp++; if (if_a.busy !== 1'b0) begin n_bad++; $display("FAIL held_idle_gap: busy got %b want 0", if_a.busy); end
    @(posedge clk); #1;
    t1 = cyc;
    n_cmp++; if (if_a.busy !== 1'b1) begin n_bad++; $display("FAIL held_restart: busy got %b want 1", if_a.busy); end
    @(negedge clk);
    start = 1'b0;
    sb.push_back(model(10, 10, 10, 10, t1 + SCAN));
    wait_done(t1, SCAN + 50, 2'b01, obs, to, pb);
    ex = sb.pop_front();
    n_cmp++; if (obs !== ex) begin n_bad++; $display("FAIL held_second: got %h want %h", obs, ex); end
    n_cmp++; if (pb !== 1'b0) begin n_bad++; $display("FAIL held_path: flag %0b want 0", pb); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_continuous;
    int t0; res_t obs, ex; bit to, pb;
    set_periods(4, 4, 4, 4);
    continuous = 1'b1;
    pulse_start(2'b10, t0);
    for (int k = 1; k <= 3; k++) sb.push_back(model(4, 4, 4, 4, t0 + k * SCAN));
    fork
      begin
        for (int k = 1; k <= 3; k++) begin
          wait_done(t0, SCAN + 50, 2'b10, obs, to, pb);
          ex = sb.pop_front();
          n_cmp++; if (obs !== ex) begin n_bad++; $display("FAIL cont_scan%0d: got %h want %h", k, obs, ex); end
          n_cmp++; if (pb !== 1'b0) begin n_bad++; $display("FAIL cont_path%0d: flag %0b want 0", k, pb); end
          if (k < 3) begin
            n_cmp++; if (if_a.busy !== 1'b1) begin n_bad++; $display("FAIL cont_busy%0d: got %b want 1", k, if_a.busy); end
          end
        end
      end
      begin
        while (cyc < t0 + 900) @(negedge clk);
        continuous = 1'b0;
      end
    join
    n_cmp++; if ({if_a.busy, if_a.scale} !== 3'b000) begin n_bad++; $display("FAIL cont_stop: busy,scale got %b want 000", {if_a.busy, if_a.scale}); end
  endtask

  task automatic test_reset_mid;
    int t0; bit seen;
    set_periods(10, 10, 10, 10);
    pulse_start(2'b11, t0);
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({if_a.scale, if_a.filter, if_a.busy, if_a.done, if_a.red_cnt, if_a.blue_cnt,
         if_a.green_cnt, if_a.clear_cnt, if_a.sat} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_a: got %h want 0", {if_a.scale, if_a.filter, if_a.busy, if_a.done,
               if_a.red_cnt, if_a.blue_cnt, if_a.green_cnt, if_a.clear_cnt, if_a.sat});
    end
    n_cmp++;
    if ({if_b.busy, if_b.red_cnt, if_b.clear_cnt, if_b.sat} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_b: got %h want 0", {if_b.busy, if_b.red_cnt, if_b.clear_cnt, if_b.sat});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (SCAN + 50) begin
      @(posedge clk); #1;
      if (if_a.done || if_b.done || if_a.busy) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL reset_mid_nodone: activity %0b want 0", seen); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; scale_cfg = 2'b00;
    set_periods(10, 10, 10, 10);
    test_reset_initial();
    test_basic();
    test_per_filter();
    test_saturation();
    test_start_ignored();
    test_start_held();
    test_continuous();
    test_reset_mid();
    n_cmp++; if (sb.size() !== 0) begin n_bad++; $display("FAIL scoreboard_drain: left %0d want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
